// File: rtl/debounce_scheduler.sv
// debounce_scheduler: time-shared button debouncer with round-robin press-event arbiter
//   clk_10mhz    : single clock, rising edge
//   rst          : synchronous active-high reset
//   btn_raw      : asynchronous raw button levels
//   btn_clean    : debounced levels
//   btn_edge     : one-cycle pulse per 0->1 debounced transition
//   event_valid  : press event offered downstream
//   event_id     : channel of the offered event
//   event_ready  : downstream accepts the event
//   lost_event   : sticky, a press was dropped while its channel was still pending
module debounce_scheduler #(
  parameter int N_BTN        = 4,
  parameter int COUNTER_BITS = 4
) (
  input  logic                     clk_10mhz,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn_raw,
  output logic [N_BTN-1:0]         btn_clean,
  output logic [N_BTN-1:0]         btn_edge,
  output logic                     event_valid,
  output logic [$clog2(N_BTN)-1:0] event_id,
  input  logic                     event_ready,
  output logic                     lost_event
);
  localparam int IW = $clog2(N_BTN);
  localparam logic [COUNTER_BITS-1:0] CMAX = '1;
  localparam logic [IW-1:0] LAST_CH = IW'(N_BTN - 1);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t state_q, state_d;
  logic [N_BTN-1:0] meta_q, sync_q;
  logic [N_BTN-1:0] clean_q, clean_d, edge_q, edge_d, pending_q, pending_d, grant_mask;
  logic [COUNTER_BITS-1:0] cnt_q [N_BTN];
  logic [COUNTER_BITS-1:0] cnt_d [N_BTN];
  logic [IW-1:0] ptr_q, ptr_d, last_q, last_d, id_q, id_d, pick, cand;
  logic lost_q, lost_d, found, grant;
  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] x);
    return (x == LAST_CH) ? '0 : x + 1'b1;
  endfunction
  always_ff @(posedge clk_10mhz) begin
    if (rst) begin
      meta_q    <= '0;
      sync_q    <= '0;
      cnt_q     <= '{default: '0};
      clean_q   <= '0;
      edge_q    <= '0;
      pending_q <= '0;
      lost_q    <= 1'b0;
      ptr_q     <= '0;
      last_q    <= LAST_CH;
      id_q      <= '0;
      state_q   <= IDLE;
    end else begin
      meta_q    <= btn_raw;
      sync_q    <= meta_q;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      edge_q    <= edge_d;
      pending_q <= pending_d;
      lost_q    <= lost_d;
      ptr_q     <= ptr_d;
      last_q    <= last_d;
      id_q      <= id_d;
      state_q   <= state_d;
    end
  end
  // Round-robin search starting just after the last accepted channel.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = nxt(last_q);
    for (int i = 0; i < N_BTN; i++) begin
      if (!found && pending_q[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
      cand = nxt(cand);
    end
  end
  assign grant      = (state_q == IDLE) && found;
  assign grant_mask = grant ? (N_BTN'(1) << pick) : '0;
  // Debounce engine services only channel ptr_q this cycle; a rise is judged
  // against the pre-clear pending bit so a press on the channel being granted is dropped.
  always_comb begin
    ptr_d     = nxt(ptr_q);
    cnt_d     = cnt_q;
    clean_d   = clean_q;
    edge_d    = '0;
    pending_d = pending_q & ~grant_mask;
    lost_d    = lost_q;
    if (sync_q[ptr_q] == clean_q[ptr_q])
      cnt_d[ptr_q] = '0;
    else if (cnt_q[ptr_q] != CMAX)
      cnt_d[ptr_q] = cnt_q[ptr_q] + 1'b1;
    else begin
      cnt_d[ptr_q]   = '0;
      clean_d[ptr_q] = sync_q[ptr_q];
      if (sync_q[ptr_q]) begin
        edge_d[ptr_q] = 1'b1;
        if (pending_q[ptr_q])
          lost_d = 1'b1;
        else
          pending_d[ptr_q] = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    last_d  = last_q;
    if (grant) begin
      state_d = OFFER;
      id_d    = pick;
    end else if (state_q == OFFER && event_ready) begin
      state_d = IDLE;
      last_d  = id_q;
    end
  end
  always_comb begin
    event_valid = (state_q == OFFER);
    event_id    = id_q;
    btn_clean   = clean_q;
    btn_edge    = edge_q;
    lost_event  = lost_q;
  end
endmodule

// File: tb/tb_debounce_scheduler.sv
// tb_debounce_scheduler: directed self-checking bench for debounce_scheduler
module tb_debounce_scheduler;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic [3:0] btn_clean, btn_edge;
  logic       event_valid, event_ready, lost_event;
  logic [1:0] event_id;
  int n_cmp = 0;
  int n_err = 0;
  int ids[$];
  int ecnt [4];
  int stall_err = 0;
  int nonzero = 0;
  int pmod = 0;
  logic prev_stall = 1'b0;
  logic [1:0] prev_id = '0;
  debounce_scheduler #(.N_BTN(4), .COUNTER_BITS(4)) dut (
    .clk_10mhz(clk), .rst(rst), .btn_raw(btn_raw), .btn_clean(btn_clean),
    .btn_edge(btn_edge), .event_valid(event_valid), .event_id(event_id),
    .event_ready(event_ready), .lost_event(lost_event)
  );
  always #50 clk = ~clk;
  // Scan position the next edge will service (0,1,2,3 from reset).
  always @(posedge clk) pmod <= rst ? 0 : (pmod + 1) % 4;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (event_valid && event_ready) ids.push_back(int'(event_id));
      for (int i = 0; i < 4; i++) if (btn_edge[i]) ecnt[i]++;
      if (prev_stall && (!event_valid || event_id != prev_id)) stall_err++;
      if (btn_clean != 0 || btn_edge != 0 || event_valid || event_id != 0 || lost_event) nonzero++;
      prev_stall = event_valid && !event_ready;
      prev_id    = event_id;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_valid(input string tag);
    int k = 0;
    while (!event_valid && k < 200) begin
      tick(1);
      k++;
    end
    check(tag, 32'(event_valid), 1);
  endtask
  task automatic clear_log;
    ids.delete();
    for (int i = 0; i < 4; i++) ecnt[i] = 0;
  endtask
  initial begin
    int lat;
    int ones;
    rst = 1'b1;
    btn_raw = '0;
    event_ready = 1'b1;
    tick(3);
    rst = 1'b0;
    check("rst_clean", 32'(btn_clean), 0);
    check("rst_edge", 32'(btn_edge), 0);
    check("rst_valid", 32'(event_valid), 0);
    check("rst_id", 32'(event_id), 0);
    check("rst_lost", 32'(lost_event), 0);
    nonzero = 0;
    tick(200);
    check("idle_200_quiet", 32'(nonzero), 0);
    // Single press on channel 2 with downstream always ready.
    clear_log();
    btn_raw[2] = 1'b1;
    lat = 0;
    while (!btn_clean[2] && lat < 100) begin
      tick(1);
      lat++;
    end
    check("ch2_latency_63_66", 32'(lat >= 63 && lat <= 66), 1);
    check("ch2_edge_with_clean", 32'(btn_edge[2]), 1);
    tick(100 - lat);
    btn_raw[2] = 1'b0;
    tick(100);
    check("ch2_released", 32'(btn_clean), 0);
    check("ch2_events", 32'(ids.size()), 1);
    if (ids.size() > 0) check("ch2_event_id", 32'(ids[0]), 2);
    check("ch2_edge_count", 32'(ecnt[2]), 1);
    // Bouncing channel 1: 3-cycle runs never reach the threshold.
    clear_log();
    for (int c = 0; c < 40; c++) begin
      btn_raw[1] = ((c / 3) % 2 == 0);
      tick(1);
    end
    btn_raw[1] = 1'b0;
    tick(100);
    check("bounce_clean", 32'(btn_clean), 0);
    check("bounce_events", 32'(ids.size()), 0);
    check("bounce_edges", 32'(ecnt[1]), 0);
    check("bounce_lost", 32'(lost_event), 0);
    // Channels 0,1,3 together, stalled; align so channel 0 is first scanned.
    clear_log();
    event_ready = 1'b0;
    while (pmod != 2) tick(1);
    btn_raw = 4'b1011;
    tick(100);
    check("stall_valid", 32'(event_valid), 1);
    check("stall_id0", 32'(event_id), 0);
    check("stall_no_handshake", 32'(ids.size()), 0);
    event_ready = 1'b1;
    tick(20);
    check("multi_count", 32'(ids.size()), 3);
    if (ids.size() == 3) begin
      check("multi_first", 32'(ids[0]), 0);
      check("multi_second", 32'(ids[1]), 1);
      check("multi_third", 32'(ids[2]), 3);
    end
    check("multi_stable", 32'(stall_err), 0);
    check("multi_valid_off", 32'(event_valid), 0);
    btn_raw = '0;
    tick(100);
    // Channel 0 occupies the offer; channel 1 pressed twice -> second press lost.
    clear_log();
    event_ready = 1'b0;
    btn_raw[0] = 1'b1;
    wait_valid("lost_ch0_offered");
    btn_raw[1] = 1'b1;
    tick(100);
    btn_raw[1] = 1'b0;
    tick(100);
    btn_raw[1] = 1'b1;
    tick(100);
    check("lost_set", 32'(lost_event), 1);
    check("lost_offer_id", 32'(event_id), 0);
    event_ready = 1'b1;
    tick(20);
    ones = 0;
    foreach (ids[i]) if (ids[i] == 1) ones++;
    check("lost_total", 32'(ids.size()), 2);
    check("lost_one_id1", 32'(ones), 1);
    check("lost_sticky", 32'(lost_event), 1);
    btn_raw = '0;
    tick(100);
    // Reset during an offer with another channel still pending.
    clear_log();
    event_ready = 1'b0;
    btn_raw = 4'b1100;
    wait_valid("rst_offer_valid");
    tick(8);
    rst = 1'b1;
    btn_raw = '0;
    tick(1);
    rst = 1'b0;
    check("rst_offer_dropped", 32'(event_valid), 0);
    check("rst_offer_lost", 32'(lost_event), 0);
    check("rst_offer_clean", 32'(btn_clean), 0);
    event_ready = 1'b1;
    tick(150);
    check("rst_no_event", 32'(ids.size()), 0);
    check("rst_stays_idle", 32'(event_valid), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
